// File: rtl/sram_like_resp.sv
// sram_like_resp: in-order SRAM-like req/addr_ok/data_ok responder over an internal word array.
// Define SRAM_RESP_RANDOM_DELAY_EN for LFSR-randomised addr_ok and response delay.
module sram_like_resp #(
  parameter int AW = 12,
  parameter int LATENCY = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(OUTSTANDING + 1);
  logic [31:0] mem [2**AW];
  logic wr_q [OUTSTANDING];
  logic wr_d [OUTSTANDING];
  logic [31:0] data_q [OUTSTANDING];
  logic [31:0] data_d [OUTSTANDING];
  logic [3:0] cnt_q [OUTSTANDING];
  logic [3:0] cnt_d [OUTSTANDING];
  logic [CW-1:0] count, count_d, wp;
  logic [AW-1:0] idx;
  logic [3:0] push_cnt;
  logic acc, pop, unused;
  int j;
  assign idx = addr[AW+1:2];
  assign unused = ^{size, addr[31:AW+2], addr[1:0]};
  assign data_ok = count != '0 && cnt_q[0] == '0;
  assign pop = data_ok;
  assign rdata = data_ok && !wr_q[0] ? data_q[0] : '0;
`ifdef SRAM_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  logic [4:0] sum;
  always_ff @(posedge clk)
    lfsr <= reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign addr_ok = (count < CW'(OUTSTANDING) || data_ok) && lfsr[0];
  assign sum = 5'(LATENCY - 1) + {3'b0, lfsr[2:1]};
  assign push_cnt = sum[4] ? 4'hf : sum[3:0];
`else
  assign addr_ok = count < CW'(OUTSTANDING) || data_ok;
  assign push_cnt = 4'(LATENCY - 1);
`endif
  assign acc = req && addr_ok;
  assign wp = count - CW'(pop);
  // Shift-down FIFO: head lives in slot 0, a new entry lands just past the survivors
  always_comb begin
    count_d = count + CW'(acc) - CW'(pop);
    j = 0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      j = (pop && i < OUTSTANDING - 1) ? i + 1 : i;
      wr_d[i] = (acc && wp == CW'(i)) ? wr : wr_q[j];
      data_d[i] = (acc && wp == CW'(i)) ? (wr ? '0 : mem[idx]) : data_q[j];
      cnt_d[i] = (acc && wp == CW'(i)) ? push_cnt : cnt_q[j] - 4'(cnt_q[j] != '0);
    end
  end
  always_ff @(posedge clk) begin
    count <= reset ? '0 : count_d;
    for (int i = 0; i < OUTSTANDING; i++) begin
      cnt_q[i] <= reset ? '0 : cnt_d[i];
      wr_q[i] <= reset ? 1'b0 : wr_d[i];
      data_q[i] <= reset ? '0 : data_d[i];
    end
  end
  always_ff @(posedge clk)
    if (acc && wr && !reset)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: randomized scoreboard bench for sram_like_resp (LATENCY=3, OUTSTANDING=2).
module tb_sram_like_resp;
  localparam int AW = 12, L = 3, O = 2;
  logic clk = 0, reset = 1, req = 0, wr = 0;
  logic [1:0] size = 2;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic addr_ok, data_ok;
  logic [31:0] rdata;

  sram_like_resp #(.AW(AW), .LATENCY(L), .OUTSTANDING(O)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic w; logic [31:0] d; int t; } ent_t;
  ent_t q[$];
  logic [31:0] mem_m [2**AW];
  int e = 0, errors = 0, checks = 0, last_pop = -10, acc_edge = 0, naccept = 0, nresp = 0;
  logic acc, obs_aok, obs_dok;
  logic [31:0] obs_rd;

  // One clock: check outputs against the queue model mid-cycle, then advance the model.
  task automatic cycle();
    logic exp_dok, ok;
    logic [31:0] exp_rd;
    logic [AW-1:0] ix;
    @(negedge clk);
    obs_aok = addr_ok; obs_dok = data_ok; obs_rd = rdata;
`ifdef SRAM_RESP_RANDOM_DELAY_EN
    ok = q.size() == 0 ? !obs_dok :
         obs_dok ? e >= q[0].t + L : e < ((q[0].t + L + 3) > (last_pop + 1) ? (q[0].t + L + 3) : (last_pop + 1));
    checks++;
    if (!ok) begin errors++; $display("FAIL data_ok_window edge=%0d got %b", e, obs_dok); end
    checks++;
    if (obs_aok && !(q.size() < O || obs_dok)) begin errors++; $display("FAIL addr_ok_full edge=%0d got 1 required 0", e); end
    exp_dok = obs_dok && q.size() > 0;
`else
    exp_dok = q.size() > 0 && e >= q[0].t + L;
    checks++;
    if (obs_dok !== exp_dok) begin errors++; $display("FAIL data_ok edge=%0d got %b required %b", e, obs_dok, exp_dok); end
    checks++;
    if (obs_aok !== (q.size() < O || exp_dok)) begin
      errors++; $display("FAIL addr_ok edge=%0d got %b required %b", e, obs_aok, q.size() < O || exp_dok);
    end
`endif
    exp_rd = (exp_dok && !q[0].w) ? q[0].d : 32'h0;
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL rdata edge=%0d got %h required %h", e, obs_rd, exp_rd); end
    acc = req && obs_aok && !reset;
    if (obs_dok) nresp++;
    if (obs_dok && q.size() > 0) begin void'(q.pop_front()); last_pop = e; end
    if (acc) begin
      ix = addr[AW+1:2];
      naccept++;
      if (wr) for (int b = 0; b < 4; b++) if (wstrb[b]) mem_m[ix][8*b +: 8] = wdata[8*b +: 8];
      q.push_back('{wr, wr ? 32'h0 : mem_m[ix], e});
    end
    if (reset) q.delete();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    req = 1; wr = w; addr = a; wdata = d; wstrb = s;
    do begin cycle(); n++; end while (!acc && n < 64);
    checks++;
    if (!acc) begin errors++; $display("FAIL accept_timeout addr=%h got no accept required accept", a); end
    acc_edge = e - 1;
    req = 0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int edge_no);
    int n = 0;
    do begin cycle(); n++; end while (!obs_dok && n < 40);
    checks++;
    if (!obs_dok) begin errors++; $display("FAIL resp_timeout got no data_ok required data_ok"); end
    d = obs_rd; edge_no = e - 1;
  endtask

  task automatic test_reset();
    cycle();
    checks += 3;
    if (obs_aok !== 1'b1) begin errors++; $display("FAIL reset_addr_ok got %b required 1", obs_aok); end
    if (obs_dok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b required 0", obs_dok); end
    if (obs_rd !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h required 0", obs_rd); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int ed;
    issue(1, 32'h0, 32'h12345678, 4'hf);
    wait_resp(d, ed);
    issue(0, 32'h0, 32'h0, 4'h0);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL basic_read got %h required 12345678", d); end
`ifndef SRAM_RESP_RANDOM_DELAY_EN
    checks++;
    if (ed - acc_edge !== L) begin errors++; $display("FAIL basic_latency got %0d required %0d", ed - acc_edge, L); end
`endif
    cycle();
    checks++;
    if (obs_rd !== 32'h0) begin errors++; $display("FAIL basic_rdata_after got %h required 0", obs_rd); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    int ed;
    issue(1, 32'h10, 32'h11223344, 4'hf);
    wait_resp(d, ed);
    issue(1, 32'h10, 32'hAABBCCDD, 4'b0101);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL strobe_write_rdata got %h required 0", d); end
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_read got %h required 11bb33dd", d); end
    issue(1, 32'h10, 32'hFFFFFFFF, 4'h0);
    wait_resp(d, ed);
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'h11BB33DD) begin errors++; $display("FAIL zero_strobe got %h required 11bb33dd", d); end
  endtask

  task automatic test_full();
    logic [31:0] addrs [4] = '{32'h0, 32'h10, 32'h0, 32'h10};
    logic [31:0] vals [4] = '{32'h12345678, 32'h11BB33DD, 32'h12345678, 32'h11BB33DD};
    logic [8:0] aok_exp = 9'b111011011, dok_exp = 9'b011011000;
    int k = 0, r = 0;
    req = 1; wr = 0; wstrb = 0;
    for (int c = 0; c < 9; c++) begin
      req = k < 4;
      addr = addrs[k < 4 ? k : 3];
      cycle();
      if (acc) k++;
`ifndef SRAM_RESP_RANDOM_DELAY_EN
      checks += 2;
      if (obs_aok !== aok_exp[c]) begin errors++; $display("FAIL full_addr_ok cycle=%0d got %b required %b", c, obs_aok, aok_exp[c]); end
      if (obs_dok !== dok_exp[c]) begin errors++; $display("FAIL full_data_ok cycle=%0d got %b required %b", c, obs_dok, dok_exp[c]); end
`endif
      if (obs_dok) begin
        checks++;
        if (obs_rd !== vals[r]) begin errors++; $display("FAIL full_order resp=%0d got %h required %h", r, obs_rd, vals[r]); end
        r++;
      end
    end
    req = 0;
  endtask

  task automatic test_alias();
    logic [31:0] d;
    int ed;
    issue(1, 32'h4000_0008, 32'hCAFEF00D, 4'hf);
    wait_resp(d, ed);
    issue(0, 32'h0000_0008, 32'h0, 4'h0);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL alias got %h required cafef00d", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int ed, seen = 0;
    issue(0, 32'h0, 32'h0, 4'h0);
    issue(0, 32'h10, 32'h0, 4'h0);
    reset = 1;
    cycle();
    reset = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (c == 0) begin
        checks++;
        if (obs_aok !== 1'b1) begin errors++; $display("FAIL reset_mid_addr_ok got %b required 1", obs_aok); end
      end
      if (obs_dok) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_dropped got %0d responses required 0", seen); end
    issue(0, 32'h8, 32'h0, 4'h0);
    wait_resp(d, ed);
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_mid_persist got %h required cafef00d", d); end
  endtask

  task automatic test_random(input int nops);
    int n = 0;
    for (int k = 0; k < 16; k++) issue(1, k * 4, $urandom, 4'hf);
    naccept = 0; nresp = q.size() > 0 ? -q.size() : 0;
    for (int k = 0; k < nops; k++) begin
      issue($urandom_range(0, 1), {$urandom_range(0, 3), 20'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
            $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) cycle();
    end
    while (q.size() > 0 && n < 200) begin cycle(); n++; end
    cycle();
    checks++;
    if (nresp != naccept) begin errors++; $display("FAIL random_count got %0d responses required %0d", nresp, naccept); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_basic();
    test_strobe();
    test_full();
    test_alias();
    test_reset_mid();
`ifdef SRAM_RESP_RANDOM_DELAY_EN
    test_random(1000);
`else
    test_random(400);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_like_resp.md
# sram_like_resp

Responder end of the core's SRAM-like `req`/`addr_ok`/`data_ok` memory interface. It accepts requests from one initiator port, such as the core's instruction or data port, and performs them in order against an internal word array. It returns one `data_ok` per accepted request after a configurable latency. It is the memory-side model/slave the pipeline's fetch and load/store units talk to in simulation and small FPGA builds.

## Interface
Parameters:
- `AW`, default 12: word-address width; array holds 2^AW 32-bit words.
- `LATENCY`, default 1: cycles from acceptance to `data_ok`; legal range 1..15.
- `OUTSTANDING`, default 2: max accepted-but-unanswered requests; legal range 1..4.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: initiator request valid.
- `wr`  in  1: 1 = write, 0 = read.
- `size`  in  2: 0 byte, 1 half, 2 word; informational only.
- `wstrb`  in  4: byte enables for writes; authoritative.
- `addr`  in  32: byte address; word index = `addr[AW+1:2]`, higher bits alias.
- `wdata`  in  32: write data.
- `addr_ok`  out  1: request accepted this cycle when `req && addr_ok`.
- `data_ok`  out  1: one-cycle response pulse, one per accepted request, in acceptance order.
- `rdata`  out  32: read data, valid only while `data_ok` is high for a read; 0 otherwise.

## Operation
- Pending FIFO of `OUTSTANDING` entries; each entry holds `{is_wr, data[31:0], cnt[3:0]}`.
- Accept = `req && addr_ok`.
  - Write: array updated at that edge, per byte where `wstrb[i]`. Push `{1, 0, LATENCY-1}`.
  - Read: array word read at that edge, so it sees all earlier writes and never later ones. Push `{0, word, LATENCY-1}`.
- Each cycle, every valid entry with `cnt != 0` decrements by one; `cnt` saturates at 0.
- `data_ok` = head valid && head `cnt == 0`. On `data_ok`, the head pops at the edge.
- `rdata` = head data when `data_ok && !head.is_wr`, else 0.
- `addr_ok` = (count < `OUTSTANDING`) || `data_ok`. Push and pop in the same cycle is allowed when full. `addr_ok` is combinational from state only, not from `req`.
- Write with `wstrb == 0`: accepted, no array change, still answered with `data_ok`.
- Read-after-write to the same word in consecutive accepts returns the new data.
- Array contents are not cleared by reset.

## Timing
- Reset values: `addr_ok` = 1, `data_ok` = 0, `rdata` = 0. FIFO is empty and the counters are cleared.
- Request accepted at edge T: `data_ok` is high in cycle T+`LATENCY`, i.e. sampled at edge T+`LATENCY`, provided no older entry is still pending.
- Back-to-back: with `OUTSTANDING >= LATENCY`, sustained one accept and one response per cycle.
- FIFO full, no response this cycle: `addr_ok` = 0. The initiator must hold `req` and its fields until accepted.
- Reset asserted mid-operation: all pending responses are dropped, with no `data_ok` for them. Writes already accepted remain in the array. `addr_ok` = 1 the cycle after reset.
- `req` deasserted: no state change except counter decrement and pop.

## Configuration
- `SRAM_RESP_RANDOM_DELAY_EN`, when defined:
  - A 16-bit Fibonacci LFSR is added, with taps 16,14,13,11 and seed 16'hACE1 on reset, stepping every cycle.
  - `addr_ok` is additionally ANDed with `lfsr[0]`.
  - Each pushed entry's `cnt` = `LATENCY-1 + lfsr[2:1]`.
  - Ordering is unchanged: a younger entry that reaches 0 waits behind the head.
- When undefined: no LFSR, deterministic timing exactly as above.

## Test plan
- Reset, then read addr 0x0 with the array preloaded with word 0 = 0x12345678, `LATENCY`=1 -> `addr_ok`=1 at accept; one cycle later `data_ok`=1, `rdata`=0x12345678; `rdata`=0 the following cycle.
- Write 0xAABBCCDD to 0x10 with `wstrb`=4'b0101, old 0x11223344, then read 0x10 -> `data_ok` for the write, then `rdata`=0x11BB33DD.
- `LATENCY`=3, `OUTSTANDING`=2, `req` held high for 4 reads -> accepts at cycles 0 and 1, `addr_ok`=0 in cycle 2, `data_ok` in cycles 3 and 4. Accepts resume in cycle 3 via pop-bypass. Responses are in order with correct data.
- Address alias with `AW`=12: write to 0x4000_0008, read 0x0000_0008 -> same word returned.
- Two reads outstanding with `LATENCY`=4, `reset` pulsed one cycle -> no `data_ok` ever for them; `addr_ok`=1 after reset; a prior write persists on re-read.
- With `SRAM_RESP_RANDOM_DELAY_EN`, 1000 random mixed accesses checked against a scoreboard -> response count equals accept count, order preserved, data matches, delay within `LATENCY`..`LATENCY`+3 when unblocked.
